// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, oversampling constants and data-length encodings.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_CNT_W  = 3;

  localparam logic [TICK_CNT_W-1:0] TICK_MAX = TICK_CNT_W'(OVERSAMPLE - 1);

  localparam logic [3:0] NBITS_6 = 4'd6;
  localparam logic [3:0] NBITS_7 = 4'd7;
  localparam logic [3:0] NBITS_8 = 4'd8;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  // Index of the last data bit; unsupported lengths fall back to 8 bits.
  function automatic logic [BIT_CNT_W-1:0] last_bit_idx(input logic [3:0] nbits);
    case (nbits)
      NBITS_6: return 3'd5;
      NBITS_7: return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [7:0] data_mask(input logic [3:0] nbits);
    case (nbits)
      NBITS_6: return 8'h3F;
      NBITS_7: return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 6/7/8 data bits LSB first, optional parity, one stop bit.
// Parity bit is built only when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter logic PARITY_ODD = 1'b0
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       TxEn,
  input  logic       Tick,
  input  logic [3:0] NBits,
  input  logic       TxStart,
  input  logic [7:0] TxData,
  output logic       Tx,
  output logic       TxBusy,
  output logic       TxDone
);

  uart_state_t           state_q, state_d;
  logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BIT_CNT_W-1:0]  last_q, last_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  bit_end;

`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`else
  // Parity sense has no effect when no parity bit is sent.
  logic                  parity_odd_unused;
  assign parity_odd_unused = PARITY_ODD;
`endif

  assign bit_end = Tick && (tick_cnt_q == TICK_MAX);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    last_d     = last_q;
    shift_d    = shift_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    if (state_q != ST_IDLE && Tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (TxStart && TxEn) begin
          shift_d    = TxData;
          last_d     = last_bit_idx(NBits);
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
`ifdef UART_TX_PARITY_EN
          // Parity over the bits actually sent, fixed at acceptance.
          parity_d   = (^(TxData & data_mask(NBits))) ^ PARITY_ODD;
`endif
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == last_q) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level follows the next state so Tx leaves a flop with no input-to-pin path.
  always_comb begin
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge Clk) begin
    shift_q  <= shift_d;
    last_q   <= last_d;
`ifdef UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
  end

  assign Tx     = tx_q;
  assign TxBusy = (state_q != ST_IDLE);
  assign TxDone = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: frames are queued at issue time and a line monitor decodes Tx against them.
module tb_uart_tx;

  localparam logic PARITY_ODD = 1'b0;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] nbits = 4'd8;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  uart_tx #(.PARITY_ODD(PARITY_ODD)) dut (
    .Clk(clk), .Rst(rst), .TxEn(tx_en), .Tick(tick), .NBits(nbits),
    .TxStart(tx_start), .TxData(tx_data), .Tx(tx), .TxBusy(tx_busy), .TxDone(tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         n;
    int         id;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0, errors = 0;
  int frames_pushed = 0, frames_done = 0, frames_aborted = 0;
  int mon_bit = -1;
  bit mon_active = 1'b0;
  bit b2b_pending = 1'b0;
  bit resume = 1'b0;
  bit go = 1'b0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int eff_nbits(input logic [3:0] nb);
    return (nb == 4'd6 || nb == 4'd7) ? int'(nb) : 8;
  endfunction

  // Expected line levels, one entry per bit period.
  function automatic void build(input logic [7:0] d, input int n,
                                output logic [15:0] bits, output int len);
    int ones = 0;
    bits = '0;
    len = 0;
    bits[len] = 1'b0; len++;
    for (int i = 0; i < n; i++) begin
      bits[len] = d[i]; len++;
      ones += int'(d[i]);
    end
    if (PAR_EN) begin
      bits[len] = ((ones % 2) == 1) ^ PARITY_ODD; len++;
    end
    bits[len] = 1'b1; len++;
  endfunction

  function automatic void push_frame(input logic [7:0] d, input logic [3:0] nb);
    frame_t f;
    f.data = d;
    f.n    = eff_nbits(nb);
    f.id   = frames_pushed;
    exp_q.push_back(f);
    frames_pushed++;
  endfunction

  // Tick source: random spacing, consecutive pulses included.
  initial begin
    forever begin
      @(posedge clk);
      #1 tick = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic run_frame();
    frame_t     f;
    logic [15:0] bits;
    int         len, ticks, cyc;
    bit         bad, first, aborted;
    int         act;
    mon_active = 1'b1;
    if (exp_q.size() == 0) begin
      check(1'b0, "spurious_frame", 1, 0);
      cyc = 0;
      while (tx_busy === 1'b1 && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      mon_active = 1'b0;
      return;
    end
    f = exp_q.pop_front();
    build(f.data, f.n, bits, len);
    first = 1'b1;
    aborted = 1'b0;
    for (int b = 0; b < len && !aborted; b++) begin
      mon_bit = b;
      ticks = 0; cyc = 0; bad = 1'b0; act = int'(bits[b]);
      while (ticks < 16 && !aborted) begin
        if (!first) @(negedge clk);
        first = 1'b0;
        cyc++;
        if (tx !== bits[b] || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
          bad = 1'b1;
          act = {29'd0, tx_busy, tx_done, tx};
        end
        if (tick) ticks++;
        if (rst) aborted = 1'b1;
        if (cyc > 400) begin
          check(1'b0, "bit_timeout", cyc, 400);
          mon_bit = -1;
          mon_active = 1'b0;
          return;
        end
      end
      if (!aborted)
        check(!bad, $sformatf("frame%0d_bit%0d", f.id, b), act, int'(bits[b]));
    end
    mon_bit = -1;
    @(negedge clk);
    if (aborted) begin
      check(tx === 1'b1, "rst_tx", int'(tx), 1);
      check(tx_busy === 1'b0, "rst_busy", int'(tx_busy), 0);
      check(tx_done === 1'b0, "rst_done", int'(tx_done), 0);
      frames_aborted++;
    end else begin
      check(tx_done === 1'b1, $sformatf("frame%0d_done", f.id), int'(tx_done), 1);
      check(tx_busy === 1'b0, $sformatf("frame%0d_done_busy", f.id), int'(tx_busy), 0);
      check(tx === 1'b1, $sformatf("frame%0d_done_tx", f.id), int'(tx), 1);
      frames_done++;
      if (b2b_pending) begin
        b2b_pending = 1'b0;
        @(negedge clk);
        check(tx_busy === 1'b1 && tx === 1'b0, "b2b_no_gap", int'({tx_busy, tx}), 2);
        resume = 1'b1;
      end
    end
    mon_active = 1'b0;
  endtask

  // Line monitor
  initial begin
    wait (go);
    forever begin
      if (!resume) @(negedge clk);
      resume = 1'b0;
      if (tx_busy === 1'b1) run_frame();
      else check(tx === 1'b1 && tx_done === 1'b0, "idle_line", int'({tx, tx_done}), 2);
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while ((tx_busy !== 1'b0 || mon_active) && n < 5000);
    check(n < 5000, "idle_timeout", n, 5000);
  endtask

  task automatic issue(input logic [7:0] d, input logic [3:0] nb);
    push_frame(d, nb);
    @(posedge clk); #2;
    tx_start = 1'b1; tx_data = d; nbits = nb;
    @(posedge clk); #2;
    tx_start = 1'b0; tx_data = 8'($urandom); nbits = 4'($urandom);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] nb;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(tx === 1'b1, "reset_tx", int'(tx), 1);
    check(tx_busy === 1'b0, "reset_busy", int'(tx_busy), 0);
    check(tx_done === 1'b0, "reset_done", int'(tx_done), 0);
    @(posedge clk); #2 rst = 1'b0;
    go = 1'b1;

    issue(8'hA5, 4'd8);
    wait_idle();
    issue(8'hD5, 4'd7);
    wait_idle();

    // Request while busy is dropped
    issue(8'h3C, 4'd8);
    repeat (100) @(posedge clk);
    #2 tx_start = 1'b1; tx_data = 8'h00; nbits = 4'd8;
    @(posedge clk); #2 tx_start = 1'b0;
    wait_idle();
    repeat (50) @(posedge clk);
    #2 check(tx_busy === 1'b0 && exp_q.size() == 0, "no_second_frame", int'(tx_busy), 0);

    // Reset during data bit 3, then a clean frame
    issue(8'h96, 4'd8);
    n = 0;
    while (mon_bit != 4 && n < 5000) begin
      @(posedge clk); n++;
    end
    check(n < 5000, "reach_bit3", n, 5000);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    wait_idle();
    issue(8'h5A, 4'd8);
    wait_idle();

    // TxStart held high across two frames
    push_frame(8'h01, 4'd8);
    @(posedge clk); #2 tx_start = 1'b1; tx_data = 8'h01; nbits = 4'd8;
    n = 0;
    do begin
      @(posedge clk); #2; n++;
    end while (tx_done !== 1'b1 && n < 5000);
    check(n < 5000, "b2b_first_done", n, 5000);
    tx_data = 8'h80;
    push_frame(8'h80, 4'd8);
    b2b_pending = 1'b1;
    @(posedge clk); #2 tx_start = 1'b0;
    wait_idle();

    issue(8'h07, 4'd8);
    wait_idle();

    // Disabled transmitter ignores requests
    tx_en = 1'b0;
    @(posedge clk); #2 tx_start = 1'b1; tx_data = 8'hFF;
    @(posedge clk); #2 tx_start = 1'b0;
    repeat (60) @(posedge clk);
    #2 check(tx_busy === 1'b0, "en_blocked", int'(tx_busy), 0);
    tx_en = 1'b1;

    // Disable mid-frame: frame still completes
    issue(8'hC3, 4'd6);
    repeat (30) @(posedge clk);
    #2 tx_en = 1'b0;
    wait_idle();
    tx_en = 1'b1;

    repeat (12) begin
      nb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(6 + $urandom_range(0, 2));
      issue(8'($urandom), nb);
      wait_idle();
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end

    repeat (20) @(posedge clk);
    #2;
    check(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
    check(frames_done + frames_aborted == frames_pushed, "frame_count",
          frames_done + frames_aborted, frames_pushed);
    check(frames_aborted == 1, "aborted_count", frames_aborted, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
